uart_tx_fifo: RTL and testbench

- Byte FIFO and launch sequencer sitting directly upstream of the UART transmitter.
- Accepts bytes from the register/bus side, buffers up to DEPTH of them, and feeds the transmitter one at a time.
- For each byte it issues a single-cycle tx_en pulse with stable byte data, then waits for the transmitter's done indication before launching the next byte.

---
 rtl/uart_tx_fifo.sv | 130 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding the UART transmitter: buffers up to
// DEPTH bytes and hands them over one at a time with a single-cycle tx_en pulse.
module uart_tx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          fifo_clr_i,
  input  logic          tx_enable_i,
  input  logic          tx_done_i,
  output logic          tx_en_o,
  output logic [7:0]    tx_byte_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic          overflow_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT
  } state_e;

  localparam logic [AW:0] LvlFull = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          done_q;
  logic          tx_en_q;
  logic [7:0]    tx_byte_q;
  state_e        state_q;

  logic full, empty, push, pop, done_rise;

  assign full      = (level_q == LvlFull);
  assign empty     = (level_q == '0);
  assign push      = wr_en_i && !full && !fifo_clr_i;
  assign pop       = (state_q == S_IDLE) && tx_enable_i && !empty && !fifo_clr_i;
  assign done_rise = tx_done_i && !done_q;

  // Clear wins over push and pop; a push while full is dropped even if a pop frees a slot.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (fifo_clr_i) begin
      wptr_d     = '0;
      rptr_d     = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_en_i && full) overflow_d = 1'b1;
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      done_q     <= tx_done_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

  // Launch sequencer; tx_byte is only reloaded on a pop so it stays put until done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      tx_en_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            tx_byte_q <= mem_q[rptr_q];
            tx_en_q   <= 1'b1;
            state_q   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tx_en_q <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (done_rise) state_q <= S_IDLE;
        end
        default: begin
          tx_en_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_en_o    = tx_en_q;
  assign tx_byte_o  = tx_byte_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a byte scoreboard checked at every launch,
// a table of fill vectors, and hand-written sequences for the multi-cycle corners.
module tb_uart_tx_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst_n;
  logic          wr_en_i;
  logic [7:0]    wr_data_i;
  logic          fifo_clr_i;
  logic          tx_enable_i;
  logic          tx_done_i;
  logic          tx_en_o;
  logic [7:0]    tx_byte_o;
  logic          full_o;
  logic          empty_o;
  logic [AW:0]   level_o;
  logic          overflow_o;
  logic          busy_o;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wr_en_i     (wr_en_i),
    .wr_data_i   (wr_data_i),
    .fifo_clr_i  (fifo_clr_i),
    .tx_enable_i (tx_enable_i),
    .tx_done_i   (tx_done_i),
    .tx_en_o     (tx_en_o),
    .tx_byte_o   (tx_byte_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic [3:0] expLevel;
    logic       expFull;
    logic       expEmpty;
    logic       expOvf;
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] sb [$];
  int         checks      = 0;
  int         passes      = 0;
  int         launchCount = 0;
  int         cyc         = 0;
  int         doneCyc     = 0;
  int         doneDelay   = 5;
  bit         gapCheck    = 0;
  bit         xmtOn       = 0;
  bit         prevTxEn    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Inputs are changed 1ns after the falling edge, after the monitor has sampled.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pushByte(input logic [7:0] b);
    wr_en_i   = 1'b1;
    wr_data_i = b;
    if (sb.size() < DEPTH) sb.push_back(b);
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    wr_en_i   = v.wr;
    wr_data_i = v.data;
    if (v.wr && sb.size() < DEPTH) sb.push_back(v.data);
    tick();
    wr_en_i = 1'b0;
    checkOutput("vecLevel", level_o, v.expLevel);
    checkOutput("vecFull", full_o, v.expFull);
    checkOutput("vecEmpty", empty_o, v.expEmpty);
    checkOutput("vecOverflow", overflow_o, v.expOvf);
  endtask

  task automatic waitIdle(input int maxCycles);
    bit ok = 0;
    for (int i = 0; i < maxCycles; i++) begin
      if (sb.size() == 0 && !busy_o && !tx_done_i) begin
        ok = 1;
        break;
      end
      tick();
    end
    checkOutput("drainedInTime", ok, 1);
  endtask

  // Launch monitor: every tx_en pulse must carry the oldest queued byte.
  initial begin
    logic [7:0] expByte;
    forever begin
      @(negedge clk);
      if (prevTxEn) checkOutput("txEnWidth", tx_en_o, 0);
      if (tx_en_o) begin
        launchCount++;
        if (sb.size() == 0) begin
          checkOutput("unexpectedLaunch", tx_en_o, 0);
        end else begin
          expByte = sb.pop_front();
          checkOutput("launchByte", tx_byte_o, expByte);
          checkOutput("launchLevel", level_o, sb.size());
        end
        if (gapCheck) begin
          checkOutput("launchGap", cyc - doneCyc, 2);
          gapCheck = 0;
        end
      end
      prevTxEn = tx_en_o;
    end
  end

  // Transmitter model: done goes high for two cycles, doneDelay cycles after a launch.
  initial begin
    forever begin
      @(negedge clk);
      while (xmtOn && tx_en_o) begin
        repeat (doneDelay) @(negedge clk);
        tx_done_i = 1'b1;
        if (sb.size() > 0 && tx_enable_i) begin
          gapCheck = 1;
          doneCyc  = cyc;
        end
        repeat (2) @(negedge clk);
        tx_done_i = 1'b0;
      end
    end
  end

  initial begin
    int base;
    vecs[0] = '{1'b1, 8'h40, 4'd1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h41, 4'd2, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h42, 4'd3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h43, 4'd4, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h44, 4'd5, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h45, 4'd6, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h46, 4'd7, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h47, 4'd8, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'h48, 4'd8, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 8'h00, 4'd8, 1'b1, 1'b0, 1'b1};

    rst_n       = 1'b0;
    wr_en_i     = 1'b0;
    wr_data_i   = 8'h00;
    fifo_clr_i  = 1'b0;
    tx_enable_i = 1'b0;
    tx_done_i   = 1'b0;
    repeat (3) tick();
    checkOutput("rstLevel", level_o, 0);
    checkOutput("rstEmpty", empty_o, 1);
    checkOutput("rstFull", full_o, 0);
    checkOutput("rstOverflow", overflow_o, 0);
    checkOutput("rstTxEn", tx_en_o, 0);
    checkOutput("rstTxByte", tx_byte_o, 8'h00);
    checkOutput("rstBusy", busy_o, 0);
    rst_n = 1'b1;
    tick();

    // Single byte: launch latency, pulse shape and busy release, with done driven by hand.
    $display("[TB] single byte launch");
    tx_enable_i = 1'b1;
    pushByte(8'hA5);
    checkOutput("t1Level", level_o, 1);
    checkOutput("t1NoLaunchYet", tx_en_o, 0);
    tick();
    checkOutput("t1Launch", tx_en_o, 1);
    checkOutput("t1Byte", tx_byte_o, 8'hA5);
    checkOutput("t1Busy", busy_o, 1);
    checkOutput("t1LevelAfterPop", level_o, 0);
    tick();
    checkOutput("t1PulseEnd", tx_en_o, 0);
    repeat (3) tick();
    checkOutput("t1BusyWait", busy_o, 1);
    tx_done_i = 1'b1;
    tick();
    checkOutput("t1BusyDrop", busy_o, 0);
    checkOutput("t1ByteHeld", tx_byte_o, 8'hA5);
    tick();
    tx_done_i = 1'b0;
    tick();

    // Three bytes queued while disabled, then drained with a slow transmitter.
    $display("[TB] three byte burst");
    xmtOn       = 1;
    doneDelay   = 100;
    tx_enable_i = 1'b0;
    pushByte(8'h11);
    pushByte(8'h22);
    pushByte(8'h33);
    checkOutput("t2Level", level_o, 3);
    base = launchCount;
    tx_enable_i = 1'b1;
    waitIdle(600);
    checkOutput("t2Launches", launchCount - base, 3);

    // Fill past full from the vector table, then drain; pointers wrap during this fill.
    $display("[TB] overflow table");
    doneDelay   = 5;
    tx_enable_i = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);
    base = launchCount;
    tx_enable_i = 1'b1;
    waitIdle(300);
    checkOutput("t3Launches", launchCount - base, 8);
    checkOutput("t3OverflowSticky", overflow_o, 1);

    // Clear, refill, then push into a full FIFO in the same cycle as the pop.
    $display("[TB] push while full during pop");
    tx_enable_i = 1'b0;
    fifo_clr_i  = 1'b1;
    tick();
    fifo_clr_i = 1'b0;
    checkOutput("t4ClrOverflow", overflow_o, 0);
    checkOutput("t4ClrEmpty", empty_o, 1);
    for (int i = 0; i < DEPTH; i++) pushByte(8'(8'h80 + i));
    checkOutput("t4Full", full_o, 1);
    base = launchCount;
    tx_enable_i = 1'b1;
    wr_en_i     = 1'b1;
    wr_data_i   = 8'hEE;
    tick();
    wr_en_i = 1'b0;
    checkOutput("t4Launch", tx_en_o, 1);
    checkOutput("t4Level", level_o, 7);
    checkOutput("t4Overflow", overflow_o, 1);
    waitIdle(300);
    checkOutput("t4Launches", launchCount - base, 8);

    // Flush with four bytes queued and one in flight.
    $display("[TB] flush with byte in flight");
    tx_enable_i = 1'b0;
    for (int i = 0; i < 5; i++) pushByte(8'(8'hC0 + i));
    base = launchCount;
    tx_enable_i = 1'b1;
    for (int i = 0; i < 10 && !busy_o; i++) tick();
    checkOutput("t5Started", launchCount - base, 1);
    checkOutput("t5LevelBefore", level_o, 4);
    checkOutput("t5OverflowBefore", overflow_o, 1);
    fifo_clr_i = 1'b1;
    sb.delete();
    tick();
    fifo_clr_i = 1'b0;
    checkOutput("t5Level", level_o, 0);
    checkOutput("t5Empty", empty_o, 1);
    checkOutput("t5Overflow", overflow_o, 0);
    checkOutput("t5BusyKept", busy_o, 1);
    checkOutput("t5ByteHeld", tx_byte_o, 8'hC0);
    repeat (20) tick();
    checkOutput("t5NoRelaunch", launchCount - base, 1);
    checkOutput("t5Idle", busy_o, 0);
    checkOutput("t5ByteAfter", tx_byte_o, 8'hC0);

    // Asynchronous reset while waiting for done.
    $display("[TB] reset during wait");
    xmtOn = 0;
    pushByte(8'h5A);
    pushByte(8'h6B);
    tick();
    checkOutput("t6Waiting", busy_o, 1);
    checkOutput("t6LevelBefore", level_o, 1);
    base = launchCount;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checkOutput("t6RstTxByte", tx_byte_o, 8'h00);
    checkOutput("t6RstBusy", busy_o, 0);
    checkOutput("t6RstLevel", level_o, 0);
    checkOutput("t6RstEmpty", empty_o, 1);
    checkOutput("t6RstTxEn", tx_en_o, 0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checkOutput("t6NoLaunch", launchCount - base, 0);
    xmtOn = 1;
    pushByte(8'h77);
    waitIdle(100);
    checkOutput("t6NewLaunch", launchCount - base, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
